// File: rtl/iob_ram_dp_be_arb_pkg.sv
// Shared types and constants for the dual-port RAM port arbiter.
// State encoding and byte-lane helpers.
package iob_ram_dp_be_arb_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int n_bytes(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Generic N-input round-robin arbiter.
// Search starts one past the last winner; pointer moves only on upd_i.
module iob_rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    input  logic [N-1:0]  req_i,
    input  logic          upd_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] r_ptr;
    logic [N-1:0]  w_gnt;
    logic [IW-1:0] w_idx;
    logic          w_any;

    // first requester found scanning upward from ptr+1, wrapping
    always_comb begin
        int j;
        j     = 0;
        w_gnt = '0;
        w_idx = '0;
        w_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(r_ptr) + k) % N;
            if (!w_any && req_i[j[IW-1:0]]) begin
                w_any             = 1'b1;
                w_gnt[j[IW-1:0]]  = 1'b1;
                w_idx             = j[IW-1:0];
            end
        end
    end

    // remember the last winner; reset value gives index 0 first priority
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_ptr <= IW'(N - 1);
        end else if (upd_i && w_any) begin
            r_ptr <= w_idx;
        end
    end

    assign gnt_o = w_gnt;
    assign idx_o = w_idx;
    assign any_o = w_any;

endmodule

// File: rtl/iob_ram_dp_be_arb.sv
// Round-robin arbiter and zero-fill sequencer for one RAM port.
// RAM outputs are combinational from state, grant and clear counter.
module iob_ram_dp_be_arb
    import iob_ram_dp_be_arb_pkg::*;
#(
    parameter  int N_REQ        = 2,
    parameter  int ADDR_W       = 10,
    parameter  int DATA_W       = 32,
    parameter  int CLEAR_ON_RST = 0,
    localparam int NB           = n_bytes(DATA_W),
    localparam int IW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
    input  logic [N_REQ*NB-1:0]     req_wstrb_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [N_REQ-1:0]        req_rvalid_o,
    output logic [DATA_W-1:0]       req_rdata_o,
    input  logic                    clear_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    ram_en_o,
    output logic [NB-1:0]           ram_we_o,
    output logic [ADDR_W-1:0]       ram_addr_o,
    output logic [DATA_W-1:0]       ram_d_o,
    input  logic [DATA_W-1:0]       ram_d_i
);

    localparam state_t RST_ST = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_done;
    logic [N_REQ-1:0]    r_rvalid;

    logic [N_REQ-1:0]    w_gnt;
    logic [IW-1:0]       w_idx;
    logic                w_any;
    logic                w_go;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NB-1:0]       w_sel_strb;
    logic                w_sel_rd;

    assign w_sel_addr = req_addr_i[int'(w_idx)*ADDR_W +: ADDR_W];
    assign w_sel_data = req_wdata_i[int'(w_idx)*DATA_W +: DATA_W];
    assign w_sel_strb = req_wstrb_i[int'(w_idx)*NB +: NB];
    assign w_sel_rd   = ~|w_sel_strb;

    // a grant is real only in RUN, out of reset, with no clear request
    assign w_go = arst_n_i && (r_state == ST_RUN) && !clear_i && w_any;

    iob_rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .req_i    (req_valid_i),
        .upd_i    (w_go),
        .gnt_o    (w_gnt),
        .idx_o    (w_idx),
        .any_o    (w_any)
    );

    // state register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= RST_ST;
        end else begin
            r_state <= w_next;
        end
    end

    // next state and RAM port mux; reset forces the port idle
    always_comb begin
        w_next      = r_state;
        req_ready_o = '0;
        ram_en_o    = 1'b0;
        ram_we_o    = '0;
        ram_addr_o  = '0;
        ram_d_o     = '0;
        unique case (r_state)
            ST_RUN: begin
                if (clear_i) begin
                    w_next = ST_CLEAR;
                end else if (w_any) begin
                    req_ready_o = w_gnt;
                    ram_en_o    = 1'b1;
                    ram_we_o    = w_sel_strb;
                    ram_addr_o  = w_sel_addr;
                    ram_d_o     = w_sel_data;
                end
            end
            ST_CLEAR: begin
                ram_en_o   = 1'b1;
                ram_we_o   = '1;
                ram_addr_o = r_cnt;
                if (&r_cnt) begin
                    w_next = ST_RUN;
                end
            end
        endcase
        if (!arst_n_i) begin
            req_ready_o = '0;
            ram_en_o    = 1'b0;
            ram_we_o    = '0;
            ram_addr_o  = '0;
            ram_d_o     = '0;
        end
    end

    // sweep address counter, held at zero outside a sweep
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // one-cycle completion pulse after the last address is written
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_CLEAR) && (&r_cnt);
        end
    end

    // read data returns one cycle after an accepted read
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= (w_go && w_sel_rd) ? w_gnt : '0;
        end
    end

    assign req_rvalid_o = r_rvalid;
    assign req_rdata_o  = ram_d_i;
    assign busy_o       = (r_state == ST_CLEAR);
    assign done_o       = r_done;

endmodule

// File: tb/tb_iob_ram_dp_be_arb.sv
// Scoreboard bench for iob_ram_dp_be_arb with a behavioural RAM.
// Directed vectors; read responses checked by a separate monitor.
module tb_iob_ram_dp_be_arb;

    localparam int N  = 2;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    typedef struct {
        int          r;
        logic [31:0] d;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      valid = '0;
    logic [N*AW-1:0]   addr_f = '0;
    logic [N*DW-1:0]   wdata_f = '0;
    logic [N*NB-1:0]   wstrb_f = '0;
    logic [N-1:0]      ready;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic              clr = 1'b0;
    logic              busy;
    logic              done;
    logic              ram_en;
    logic [NB-1:0]     ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_d;
    logic [DW-1:0]     ram_q;

    logic [DW-1:0]     mem [2**AW];

    exp_t              q[$];
    exp_t              mon_e;
    int                n_chk = 0;
    int                n_fail = 0;
    int                n_done = 0;

    always #5 clk = ~clk;

    iob_ram_dp_be_arb #(
        .N_REQ        (N),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .CLEAR_ON_RST (1)
    ) dut (
        .clk_i        (clk),
        .arst_n_i     (rst_n),
        .req_valid_i  (valid),
        .req_addr_i   (addr_f),
        .req_wdata_i  (wdata_f),
        .req_wstrb_i  (wstrb_f),
        .req_ready_o  (ready),
        .req_rvalid_o (rvalid),
        .req_rdata_o  (rdata),
        .clear_i      (clr),
        .busy_o       (busy),
        .done_o       (done),
        .ram_en_o     (ram_en),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_d_o      (ram_d),
        .ram_d_i      (ram_q)
    );

    // read-first byte-enable RAM, one cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            ram_q <= mem[ram_addr];
            for (int b = 0; b < NB; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: pop one expectation per rvalid bit seen
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) n_done++;
            for (int i = 0; i < N; i++) begin
                if (rvalid[i]) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rvalid", 64'(i), 64'hffff);
                    end else begin
                        mon_e = q.pop_front();
                        chk("rvalid_req", 64'(i), 64'(mon_e.r));
                        chk("rdata", 64'(rdata), 64'(mon_e.d));
                    end
                end
            end
        end
    end

    task automatic set_req(input int r, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [NB-1:0] s);
        addr_f[r*AW +: AW]  = a;
        wdata_f[r*DW +: DW] = d;
        wstrb_f[r*NB +: NB] = s;
    endtask

    task automatic do_write(input int r, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [NB-1:0] s);
        @(negedge clk);
        set_req(r, a, d, s);
        valid = N'(1 << r);
        #1 chk("wr_ready", 64'(ready), 64'(1 << r));
        @(negedge clk);
        valid = '0;
        #1 chk("wr_no_rvalid", 64'(rvalid), 64'h0);
    endtask

    task automatic do_read(input int r, input logic [AW-1:0] a,
                           input logic [DW-1:0] e);
        @(negedge clk);
        set_req(r, a, '0, '0);
        valid = N'(1 << r);
        #1 chk("rd_ready", 64'(ready), 64'(1 << r));
        q.push_back('{r, e});
        @(negedge clk);
        valid = '0;
        #1;
    endtask

    // caller is 1 time unit past the negedge where address 0 is presented
    task automatic check_sweep(input string tag);
        int k;
        k = 0;
        while (busy && k < 40) begin
            chk({tag, "_addr"}, 64'(ram_addr), 64'(k));
            chk({tag, "_we"}, 64'(ram_we), 64'hf);
            chk({tag, "_d"}, 64'(ram_d), 64'h0);
            chk({tag, "_ready"}, 64'(ready), 64'h0);
            chk({tag, "_done_low"}, 64'(done), 64'h0);
            k++;
            @(negedge clk);
            #1;
        end
        valid = '0;
        chk({tag, "_cycles"}, 64'(k), 64'd16);
        chk({tag, "_done"}, 64'(done), 64'h1);
        @(negedge clk);
        #1 chk({tag, "_done_pulse"}, 64'(done), 64'h0);
        chk({tag, "_idle"}, 64'(busy), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        // reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_en", 64'(ram_en), 64'h0);
        chk("rst_we", 64'(ram_we), 64'h0);
        chk("rst_addr", 64'(ram_addr), 64'h0);
        chk("rst_d", 64'(ram_d), 64'h0);
        chk("rst_busy", 64'(busy), 64'h1);

        // automatic sweep after release
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_sweep("auto");

        // preload; leaves the pointer on requester 1
        do_write(0, 4'd5, 32'hDEADBEEF, 4'hf);
        do_write(1, 4'd3, 32'hAABBCCDD, 4'hf);

        // contention: both valid four cycles, grants 0,1,0,1
        @(negedge clk);
        set_req(0, 4'd5, '0, '0);
        set_req(1, 4'd3, '0, '0);
        valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1 chk("rr_grant", 64'(ready), (c % 2 == 0) ? 64'h1 : 64'h2);
            q.push_back('{c % 2, (c % 2 == 0) ? 32'hDEADBEEF : 32'hAABBCCDD});
            @(negedge clk);
        end
        valid = '0;

        // single read and byte-masked write
        do_read(0, 4'd5, 32'hDEADBEEF);
        do_write(1, 4'd3, 32'h11223344, 4'b0101);
        do_read(1, 4'd3, 32'hAA22CC44);

        // clear arriving one cycle after an accepted read
        @(negedge clk);
        set_req(0, 4'd5, '0, '0);
        valid = 2'b01;
        #1 chk("pend_ready", 64'(ready), 64'h1);
        q.push_back('{0, 32'hDEADBEEF});
        @(negedge clk);
        clr   = 1'b1;
        valid = 2'b11;
        #1 chk("clr_no_grant", 64'(ready), 64'h0);
        chk("clr_no_en", 64'(ram_en), 64'h0);
        @(negedge clk);
        clr = 1'b0;
        #1 check_sweep("clr");
        for (int a = 0; a < 2**AW; a++) begin
            do_read(0, AW'(a), 32'h0);
        end

        // reset in the middle of a sweep
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        k = 0;
        while (ram_addr != 4'd7 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("mid_addr", 64'(ram_addr), 64'd7);
        rst_n = 1'b0;
        #1 chk("mid_busy", 64'(busy), 64'h1);
        chk("mid_en", 64'(ram_en), 64'h0);
        chk("mid_addr0", 64'(ram_addr), 64'h0);
        chk("mid_done", 64'(done), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check_sweep("restart");

        repeat (2) @(negedge clk);
        chk("done_count", 64'(n_done), 64'd3);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
